// File: rtl/alarm_minigame_gen.sv
// Alarm mini-game controller for the alarm-clock mode path.
// Rings on an alarm match until the centre button is pressed, then plays a
// whack-a-mole round game on N_LED LEDs/switches until WIN_COUNT consecutive
// hits dismiss the alarm. All timing, edge detection and randomness are
// derived from the single 1 ms clock.
module alarm_minigame_gen #(
    parameter int N_LED     = 10,
    parameter int WIN_COUNT = 3,
    parameter int ROUND_MS  = 2000,
    parameter int STEP_MS   = 250,
    parameter int MIN_MS    = 750,
    parameter int BLINK_MS  = 500,
    parameter int CNT_W     = 4
) (
    input  logic             CLOCK_1ms,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [11:0]      current_time,
    input  logic [11:0]      alarm_time,
    input  logic [N_LED-1:0] spdt,
    input  logic             push_button_center,
    output logic [1:0]       minigame_activated,
    output logic [N_LED-1:0] LED,
    output logic [CNT_W-1:0] count,
    output logic             blink,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RING = 2'b01;
    localparam logic [1:0] ST_GAME = 2'b10;

    // Wide enough that count*STEP_MS + MIN_MS can never wrap.
    localparam int PW = CNT_W + 17;

    localparam logic [15:0]      BLINK_LAST = 16'(BLINK_MS - 1);
    localparam logic [CNT_W-1:0] WIN_VAL    = CNT_W'(WIN_COUNT);
    localparam logic [7:0]       LED_LAST   = 8'(N_LED - 1);

    // Registered state
    logic [1:0]       state_reg, state_next;
    logic [N_LED-1:0] led_reg, led_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             blink_reg, blink_next;
    logic             done_reg, done_next;
    logic [15:0]      timer_reg, timer_next;
    logic             rearm_reg, rearm_next;
    logic [7:0]       last_idx_reg, last_idx_next;
    logic             last_valid_reg, last_valid_next;
    logic [15:0]      lfsr_reg;

    // Input conditioning registers
    logic             enable_d_reg;
    logic             btn_s1_reg, btn_s2_reg, btn_prev_reg;
    logic [N_LED-1:0] spdt_r_reg, spdt_rr_reg;

    // Derived combinational signals
    logic             enable_rise;
    logic             btn_rise;
    logic [N_LED-1:0] sw_rise;
    logic [4:0]       sw_cnt;
    logic             time_match;
    logic             lfsr_fb;
    logic [7:0]       idx_raw, idx_inc, idx_sel;
    logic [N_LED-1:0] led_onehot;
    logic [PW-1:0]    step_total;
    logic [15:0]      period;
    logic             expire;

    assign enable_rise = ENABLE & ~enable_d_reg;
    assign btn_rise    = btn_s2_reg & ~btn_prev_reg;
    assign sw_rise     = spdt_r_reg & ~spdt_rr_reg;
    assign time_match  = (current_time == alarm_time);

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    // Pick a target index, stepping past the previously lit one so the
    // same LED never lights twice in a row.
    assign idx_raw = lfsr_reg[7:0] % 8'(N_LED);
    assign idx_inc = (idx_raw == LED_LAST) ? 8'd0 : idx_raw + 8'd1;
    assign idx_sel = (last_valid_reg && (idx_raw == last_idx_reg)) ? idx_inc : idx_raw;

    // One-hot decode of the chosen index
    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_onehot
            assign led_onehot[gi] = (idx_sel == 8'(gi));
        end
    endgenerate

    // Number of switches that rose this cycle
    always_comb begin
        sw_cnt = 5'd0;
        for (int i = 0; i < N_LED; i++) begin
            sw_cnt = sw_cnt + 5'(sw_rise[i]);
        end
    end

    // Round period shrinks with the current streak, clamped at MIN_MS
    always_comb begin
        step_total = PW'(count_reg) * PW'(STEP_MS);
        if ((step_total + PW'(MIN_MS)) >= PW'(ROUND_MS)) begin
            period = 16'(MIN_MS);
        end else begin
            period = 16'(PW'(ROUND_MS) - step_total);
        end
    end

    // >= rather than == so a period that shrinks mid-round still expires
    assign expire = (timer_reg >= (period - 16'd1));

    // Next-state logic for the idle / ring / game controller
    always_comb begin
        state_next      = state_reg;
        led_next        = led_reg;
        count_next      = count_reg;
        blink_next      = blink_reg;
        done_next       = 1'b0;
        timer_next      = timer_reg;
        last_idx_next   = last_idx_reg;
        last_valid_next = last_valid_reg;
        // The rearm block only clears once the minute has moved on
        rearm_next      = time_match ? rearm_reg : 1'b0;

        if (enable_rise) begin
            state_next      = ST_IDLE;
            led_next        = '0;
            count_next      = '0;
            blink_next      = 1'b0;
            timer_next      = 16'd0;
            rearm_next      = 1'b0;
            last_idx_next   = 8'd0;
            last_valid_next = 1'b0;
        end else if (ENABLE) begin
            case (state_reg)
                ST_IDLE: begin
                    led_next   = '0;
                    blink_next = 1'b0;
                    if (time_match && !rearm_reg) begin
                        state_next = ST_RING;
                        timer_next = 16'd0;
                    end
                end
                ST_RING: begin
                    if (btn_rise) begin
                        state_next = ST_GAME;
                        blink_next = 1'b0;
                        count_next = '0;
                        led_next   = '0;
                        timer_next = 16'd0;
                    end else if (timer_reg >= BLINK_LAST) begin
                        timer_next = 16'd0;
                        blink_next = ~blink_reg;
                    end else begin
                        timer_next = timer_reg + 16'd1;
                    end
                end
                ST_GAME: begin
                    if (count_reg == WIN_VAL) begin
                        state_next = ST_IDLE;
                        led_next   = '0;
                        count_next = '0;
                        done_next  = 1'b1;
                        rearm_next = 1'b1;
                        timer_next = 16'd0;
                    end else if (expire) begin
                        // Expiry beats any switch edge in the same cycle
                        timer_next      = 16'd0;
                        if (led_reg != '0) begin
                            count_next = '0;
                        end
                        led_next        = led_onehot;
                        last_idx_next   = idx_sel;
                        last_valid_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 16'd1;
                        if (sw_cnt > 5'd1) begin
                            count_next = '0;
                            led_next   = '0;
                        end else if ((sw_cnt == 5'd1) && (led_reg != '0)) begin
                            if ((sw_rise == led_reg) && (count_reg != WIN_VAL)) begin
                                count_next = count_reg + 1'b1;
                            end else begin
                                count_next = '0;
                            end
                            led_next = '0;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    led_next   = '0;
                    count_next = '0;
                    blink_next = 1'b0;
                    timer_next = 16'd0;
                end
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge CLOCK_1ms) begin
        if (RESET) begin
            state_reg      <= ST_IDLE;
            led_reg        <= '0;
            count_reg      <= '0;
            blink_reg      <= 1'b0;
            done_reg       <= 1'b0;
            timer_reg      <= 16'd0;
            rearm_reg      <= 1'b0;
            last_idx_reg   <= 8'd0;
            last_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            led_reg        <= led_next;
            count_reg      <= count_next;
            blink_reg      <= blink_next;
            done_reg       <= done_next;
            timer_reg      <= timer_next;
            rearm_reg      <= rearm_next;
            last_idx_reg   <= last_idx_next;
            last_valid_reg <= last_valid_next;
        end
    end

    // LFSR free-runs regardless of ENABLE; only RESET reseeds it
    always_ff @(posedge CLOCK_1ms) begin
        if (RESET) begin
            lfsr_reg <= 16'h0001;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    // ENABLE edge register
    always_ff @(posedge CLOCK_1ms) begin
        if (RESET) begin
            enable_d_reg <= 1'b0;
        end else begin
            enable_d_reg <= ENABLE;
        end
    end

    // Button synchroniser/edge detector and switch edge registers
    always_ff @(posedge CLOCK_1ms) begin
        if (RESET || enable_rise) begin
            btn_s1_reg   <= 1'b0;
            btn_s2_reg   <= 1'b0;
            btn_prev_reg <= 1'b0;
            spdt_r_reg   <= '0;
            spdt_rr_reg  <= '0;
        end else begin
            btn_s1_reg   <= push_button_center;
            btn_s2_reg   <= btn_s1_reg;
            btn_prev_reg <= btn_s2_reg;
            spdt_r_reg   <= spdt;
            spdt_rr_reg  <= spdt_r_reg;
        end
    end

    assign minigame_activated = state_reg;
    assign LED                = led_reg;
    assign count              = count_reg;
    assign blink              = blink_reg;
    assign done               = done_reg;

endmodule

// File: tb/tb_alarm_minigame_gen.sv
// Directed bench for alarm_minigame_gen: reset, ring/blink timing, button
// latency, table of game rounds, win/rearm, ENABLE freeze and reset mid-game.
module tb_alarm_minigame_gen;

    localparam int N = 10;

    localparam int K_HIT    = 0;
    localparam int K_WRONG  = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_MISS   = 3;

    typedef struct {
        int kind;
        int exp_count;
        int exp_period;   // 0: LED already lit, no period check
    } vec_t;

    logic          CLOCK_1ms;
    logic          RESET;
    logic          ENABLE;
    logic [11:0]   current_time;
    logic [11:0]   alarm_time;
    logic [N-1:0]  spdt;
    logic          push_button_center;
    logic [1:0]    minigame_activated;
    logic [N-1:0]  LED;
    logic [3:0]    count;
    logic          blink;
    logic          done;

    int total;
    int bad;
    int cyc;
    int last_light;

    vec_t vecs[10];

    alarm_minigame_gen dut (
        .CLOCK_1ms          (CLOCK_1ms),
        .RESET              (RESET),
        .ENABLE             (ENABLE),
        .current_time       (current_time),
        .alarm_time         (alarm_time),
        .spdt               (spdt),
        .push_button_center (push_button_center),
        .minigame_activated (minigame_activated),
        .LED                (LED),
        .count              (count),
        .blink              (blink),
        .done               (done)
    );

    initial CLOCK_1ms = 1'b0;
    always #5 CLOCK_1ms = ~CLOCK_1ms;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_1ms);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, expv, cyc);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    function automatic int led_index(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Wait (bounded) for an LED to light; report cycles since previous light
    task automatic wait_led(output int per);
        int n;
        n = 0;
        while (LED == '0 && n < 5000) begin
            tick(1);
            n++;
        end
        if (LED == '0) begin
            total++;
            bad++;
            $display("FAIL wait_led timeout got=LED0 expected=lit (cycle %0d)", cyc);
            per = -1;
        end else begin
            per = cyc - last_light;
            last_light = cyc;
        end
    endtask

    // Raise a switch pattern and check the score two edges later
    task automatic press(input logic [N-1:0] pat, input int exp_cnt, input string tag);
        spdt = pat;
        tick(2);
        check({tag, "_count"}, int'(count), exp_cnt);
        check({tag, "_led_off"}, int'(LED), 0);
        spdt = '0;
    endtask

    // Button press: state must be GAME exactly three edges after raw edge
    task automatic start_game(input string tag);
        push_button_center = 1'b1;
        tick(1);
        check({tag, "_btn_e1"}, int'(minigame_activated), 1);
        tick(1);
        check({tag, "_btn_e2"}, int'(minigame_activated), 1);
        tick(1);
        check({tag, "_btn_e3"}, int'(minigame_activated), 2);
        last_light = cyc;
        tick(17);
        push_button_center = 1'b0;
    endtask

    initial begin
        int per;
        int li;
        logic [N-1:0] lit;
        logic [N-1:0] other;
        logic [N-1:0] saved;

        total = 0;
        bad = 0;
        cyc = 0;
        last_light = 0;

        vecs[0] = '{K_HIT,    1, 2000};
        vecs[1] = '{K_HIT,    2, 1750};
        vecs[2] = '{K_WRONG,  0, 1500};
        vecs[3] = '{K_DOUBLE, 0, 2000};
        vecs[4] = '{K_HIT,    1, 2000};
        vecs[5] = '{K_HIT,    2, 1750};
        vecs[6] = '{K_MISS,   0, 1500};
        vecs[7] = '{K_HIT,    1, 0};
        vecs[8] = '{K_HIT,    2, 1750};
        vecs[9] = '{K_HIT,    3, 1500};

        RESET = 1'b1;
        ENABLE = 1'b1;
        current_time = 12'h730;
        alarm_time = 12'h000;
        spdt = '0;
        push_button_center = 1'b0;

        tick(3);
        check("rst_state", int'(minigame_activated), 0);
        check("rst_led", int'(LED), 0);
        check("rst_count", int'(count), 0);
        check("rst_blink", int'(blink), 0);
        check("rst_done", int'(done), 0);
        RESET = 1'b0;
        tick(3);
        check("idle_nomatch", int'(minigame_activated), 0);

        // Alarm match -> ring one cycle later, blink every 500 cycles
        alarm_time = 12'h730;
        tick(1);
        check("ring_entry", int'(minigame_activated), 1);
        check("ring_blink0", int'(blink), 0);
        tick(499);
        check("blink_499", int'(blink), 0);
        tick(1);
        check("blink_500", int'(blink), 1);
        tick(500);
        check("blink_1000", int'(blink), 0);
        tick(500);
        check("blink_1500", int'(blink), 1);

        start_game("g1");
        check("g1_blink_off", int'(blink), 0);
        check("g1_count0", int'(count), 0);

        // Table of game rounds
        for (int i = 0; i < 10; i++) begin
            if (LED == '0) begin
                wait_led(per);
                if (vecs[i].exp_period != 0)
                    check($sformatf("v%0d_period", i), per, vecs[i].exp_period);
            end
            check($sformatf("v%0d_onehot", i), $countones(LED), 1);
            lit = LED;
            li = led_index(LED);
            other = onehot((li + 1) % N);
            case (vecs[i].kind)
                K_HIT:    press(lit, vecs[i].exp_count, $sformatf("v%0d_hit", i));
                K_WRONG:  press(other, vecs[i].exp_count, $sformatf("v%0d_wrong", i));
                K_DOUBLE: press(lit | other, vecs[i].exp_count, $sformatf("v%0d_double", i));
                default: begin
                    // Unanswered round; matching switch edge lands on the expiry cycle
                    tick(1498);
                    check($sformatf("v%0d_pre_count", i), int'(count), 2);
                    spdt = lit;
                    tick(2);
                    check($sformatf("v%0d_exp_count", i), int'(count), vecs[i].exp_count);
                    check($sformatf("v%0d_exp_onehot", i), $countones(LED), 1);
                    check($sformatf("v%0d_led_moved", i), int'(LED != lit), 1);
                    saved = LED;
                    last_light = cyc;
                    tick(1);
                    check($sformatf("v%0d_edge_ignored_led", i), int'(LED), int'(saved));
                    check($sformatf("v%0d_edge_ignored_cnt", i), int'(count), 0);
                    spdt = '0;
                    tick(2);
                end
            endcase
        end

        // Win: done pulse, back to idle, rearm blocks retrigger
        tick(1);
        check("win_state", int'(minigame_activated), 0);
        check("win_done", int'(done), 1);
        check("win_count", int'(count), 0);
        check("win_led", int'(LED), 0);
        tick(1);
        check("win_done_clear", int'(done), 0);
        check("rearm_hold", int'(minigame_activated), 0);
        tick(5);
        check("rearm_hold5", int'(minigame_activated), 0);
        current_time = 12'h731;
        tick(2);
        check("minute_change", int'(minigame_activated), 0);
        current_time = 12'h730;
        tick(1);
        check("retrigger", int'(minigame_activated), 1);

        // ENABLE low freezes the game
        start_game("g2");
        wait_led(per);
        check("g2_period0", per, 2000);
        press(LED, 1, "g2_hit");
        wait_led(per);
        check("g2_period1", per, 1750);
        ENABLE = 1'b0;
        saved = LED;
        tick(5000);
        check("frz_led", int'(LED), int'(saved));
        check("frz_count", int'(count), 1);
        check("frz_state", int'(minigame_activated), 2);
        ENABLE = 1'b1;
        tick(1);
        check("en_rise_state", int'(minigame_activated), 0);
        check("en_rise_count", int'(count), 0);
        check("en_rise_led", int'(LED), 0);

        // RESET mid-game with count 2 and an LED lit
        tick(1);
        check("g3_ring", int'(minigame_activated), 1);
        start_game("g3");
        wait_led(per);
        check("g3_period0", per, 2000);
        press(LED, 1, "g3_hit1");
        wait_led(per);
        check("g3_period1", per, 1750);
        press(LED, 2, "g3_hit2");
        wait_led(per);
        check("g3_period2", per, 1500);
        check("g3_pre_count", int'(count), 2);
        RESET = 1'b1;
        tick(1);
        check("mid_rst_state", int'(minigame_activated), 0);
        check("mid_rst_led", int'(LED), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_blink", int'(blink), 0);
        RESET = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
